// File: rtl/odometry_pkg.sv
// Shared odometry definitions: heading-encoder FSM states, angle width and
// scale, and the sign/magnitude helper used when restoring a signed result.
// Ports: none (package).
package odometry_pkg;

   localparam int unsigned ANGLE_W   = 64;
   localparam int unsigned TICK_W    = 32;
   localparam int unsigned DIFF_W    = 33;
   localparam int unsigned DIV_STEPS = 64;
   localparam int unsigned DIV_CNT_W = 7;

   // Microradians per radian.
   localparam logic [ANGLE_W-1:0] ANGLE_SCALE = 64'd1000000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } enc_state_t;

   typedef struct packed {
      logic               neg;
      logic [ANGLE_W-1:0] mag;
   } signed_mag_t;

   // Re-applies the sign to an unsigned magnitude; zero never becomes negative.
   function automatic logic signed [ANGLE_W-1:0] apply_sign(input signed_mag_t v);
      if (v.neg && (v.mag != '0)) begin
         return -$signed(v.mag);
      end
      return $signed(v.mag);
   endfunction

endpackage

// File: rtl/seq_divider_u64.sv
// 64/64 unsigned restoring divider, one quotient bit per cycle, 64 cycles.
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   load          - capture dividend/divisor and start a division
//   dividend      - 64-bit unsigned numerator
//   divisor       - 64-bit unsigned denominator (non-zero)
//   done_c        - high in the cycle whose clock edge retires the last bit
//   quotient_c    - quotient including the bit retired this cycle; final when done_c
module seq_divider_u64
   import odometry_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic [ANGLE_W-1:0] dividend,
   input  logic [ANGLE_W-1:0] divisor,
   output logic               done_c,
   output logic [ANGLE_W-1:0] quotient_c
);

   logic [ANGLE_W-1:0]   rem_q;
   logic [ANGLE_W-1:0]   quo_q;
   logic [ANGLE_W-1:0]   dvs_q;
   logic [DIV_CNT_W-1:0] cnt_q;

   logic [ANGLE_W:0]     rem_sh;
   logic [ANGLE_W:0]     trial;
   logic                 fits;
   logic [ANGLE_W-1:0]   rem_d;
   logic [ANGLE_W-1:0]   quo_d;

   // One restoring step: shift in the next dividend bit, subtract if it fits.
   // Since rem < divisor, trial[64] is set exactly when the subtraction borrows.
   always_comb begin
      rem_sh = {rem_q, quo_q[ANGLE_W-1]};
      trial  = rem_sh - {1'b0, dvs_q};
      fits   = ~trial[ANGLE_W];
      rem_d  = fits ? trial[ANGLE_W-1:0] : rem_sh[ANGLE_W-1:0];
      quo_d  = {quo_q[ANGLE_W-2:0], fits};
   end

   assign quotient_c = quo_d;
   assign done_c     = (cnt_q == DIV_CNT_W'(1));

   // Dividend shifts out of quo_q from the top while quotient bits enter below.
   always_ff @(posedge clk) begin
      if (reset) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
      end else if (load) begin
         rem_q <= '0;
         quo_q <= dividend;
         dvs_q <= divisor;
         cnt_q <= DIV_CNT_W'(DIV_STEPS);
      end else if (cnt_q != '0) begin
         rem_q <= rem_d;
         quo_q <= quo_d;
         cnt_q <= cnt_q - DIV_CNT_W'(1);
      end
   end

endmodule

// File: rtl/delta_theta_encoder.sv
// Converts left/right encoder tick deltas into a heading change in microradians:
//   delta_theta = trunc((ticks_right - ticks_left) * UM_PER_TICK * 1e6 / WHEELBASE_UM)
// Ports:
//   clk, reset               - clock, synchronous active-high reset
//   sample                   - one-cycle strobe qualifying ticks_left/ticks_right
//   ticks_left, ticks_right  - signed 32-bit tick deltas since the previous sample
//   delta_theta              - signed 64-bit heading change, updated only in DONE
//   start                    - one-cycle pulse marking a new delta_theta
//   busy                     - high during LOAD, DIV and DONE
//   overrun                  - sticky: a sample arrived while busy (cleared by reset)
module delta_theta_encoder
   import odometry_pkg::*;
#(
   parameter int unsigned UM_PER_TICK  = 100,
   parameter int unsigned WHEELBASE_UM = 200000
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      sample,
   input  logic signed [TICK_W-1:0]  ticks_left,
   input  logic signed [TICK_W-1:0]  ticks_right,
   output logic signed [ANGLE_W-1:0] delta_theta,
   output logic                      start,
   output logic                      busy,
   output logic                      overrun
);

   if (WHEELBASE_UM == 0) begin : g_bad_wheelbase
      $fatal(1, "delta_theta_encoder: WHEELBASE_UM must be greater than zero");
   end
   if ((UM_PER_TICK < 1) || (UM_PER_TICK > 2000)) begin : g_bad_um_per_tick
      $fatal(1, "delta_theta_encoder: UM_PER_TICK must be in 1..2000");
   end

   // Combined scale fits in 31 bits; times a 33-bit magnitude stays below 2^63.
   localparam logic [ANGLE_W-1:0] NUM_SCALE = ANGLE_W'(UM_PER_TICK) * ANGLE_SCALE;
   localparam logic [ANGLE_W-1:0] DIVISOR   = ANGLE_W'(WHEELBASE_UM);

   enc_state_t                state;
   enc_state_t                state_d;
   logic signed [TICK_W-1:0]  tick_l;
   logic signed [TICK_W-1:0]  tick_r;
   logic                      neg;
   logic signed [ANGLE_W-1:0] delta_theta_d;
   logic                      start_d;
   logic                      busy_d;
   logic                      overrun_d;
   logic                      accept;
   logic                      load;

   logic signed [DIFF_W-1:0]  diff;
   logic [DIFF_W-1:0]         diff_mag;
   signed_mag_t               num;
   signed_mag_t               result;
   logic                      div_done_c;
   logic [ANGLE_W-1:0]        div_quotient_c;

   // Numerator from the latched ticks, valid in the LOAD cycle.
   always_comb begin
      diff     = DIFF_W'(tick_r) - DIFF_W'(tick_l);
      diff_mag = diff[DIFF_W-1] ? $unsigned(-diff) : $unsigned(diff);
      num.neg  = diff[DIFF_W-1];
      num.mag  = ANGLE_W'(diff_mag) * NUM_SCALE;
   end

   assign result = {neg, div_quotient_c};

   seq_divider_u64 u_div (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .dividend   (num.mag),
      .divisor    (DIVISOR),
      .done_c     (div_done_c),
      .quotient_c (div_quotient_c)
   );

   // State register and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         delta_theta <= '0;
         start       <= 1'b0;
         busy        <= 1'b0;
         overrun     <= 1'b0;
         tick_l      <= '0;
         tick_r      <= '0;
         neg         <= 1'b0;
      end else begin
         state       <= state_d;
         delta_theta <= delta_theta_d;
         start       <= start_d;
         busy        <= busy_d;
         overrun     <= overrun_d;
         if (accept) begin
            tick_l <= ticks_left;
            tick_r <= ticks_right;
         end
         if (load) begin
            neg <= num.neg;
         end
      end
   end

   // Next state and next output values; the result lands on the edge into DONE.
   always_comb begin
      state_d       = state;
      delta_theta_d = delta_theta;
      start_d       = 1'b0;
      accept        = 1'b0;
      load          = 1'b0;
      overrun_d     = overrun | (sample && (state != IDLE));
      case (state)
         IDLE: begin
            if (sample) begin
               accept  = 1'b1;
               state_d = LOAD;
            end
         end
         LOAD: begin
            load    = 1'b1;
            state_d = DIV;
         end
         DIV: begin
            if (div_done_c) begin
               state_d       = DONE;
               start_d       = 1'b1;
               delta_theta_d = apply_sign(result);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

endmodule
